// File: rtl/rv32_wb_port_arbiter.sv
// Round-robin arbiter for the register-file write port, followed by one registered
// writeback stage. Also holds the busy scoreboard that decode uses for RAW/WAW stalls.
module rv32_wb_port_arbiter #(
    parameter int NREQ       = 3,
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*REG_ADDR_W-1:0] req_rd,
    input  logic [NREQ*XLEN-1:0]       req_data,
    output logic                       wb_wr_en,
    output logic [REG_ADDR_W-1:0]      wb_rd_addr,
    output logic [XLEN-1:0]            wb_rd_data,
    input  logic                       sb_set_en,
    input  logic [REG_ADDR_W-1:0]      sb_set_addr,
    input  logic [REG_ADDR_W-1:0]      chk_rs1,
    input  logic [REG_ADDR_W-1:0]      chk_rs2,
    input  logic [REG_ADDR_W-1:0]      chk_rd,
    output logic                       hazard,
    output logic [31:0]                busy
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [REG_ADDR_W-1:0] rd_arr   [NREQ];
    logic [XLEN-1:0]       data_arr [NREQ];

    logic [GW-1:0]         last_gnt;
    logic [GW-1:0]         cand;
    logic                  gnt_vld;
    logic [GW-1:0]         gnt_idx;
    logic [REG_ADDR_W-1:0] gnt_rd;
    logic [XLEN-1:0]       gnt_data;
    logic [31:0]           busy_nxt;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign rd_arr[i]   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
        assign data_arr[i] = req_data[i*XLEN +: XLEN];
    end

    // Arbitration: scan last_gnt+1 .. last_gnt+NREQ (mod NREQ), first valid wins
    always_comb begin
        cand      = '0;
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        gnt_rd    = '0;
        gnt_data  = '0;
        req_ready = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_gnt) + k) % NREQ);
            if (!gnt_vld && req_valid[cand]) begin
                gnt_vld  = 1'b1;
                gnt_idx  = cand;
                gnt_rd   = rd_arr[cand];
                gnt_data = data_arr[cand];
            end
        end
        if (gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Writeback stage: address/data hold when idle, only the enable drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt   <= GW'(NREQ - 1);
            wb_wr_en   <= 1'b0;
            wb_rd_addr <= '0;
            wb_rd_data <= '0;
        end else begin
            wb_wr_en <= gnt_vld && (gnt_rd != '0);
            if (gnt_vld) begin
                last_gnt   <= gnt_idx;
                wb_rd_addr <= gnt_rd;
                wb_rd_data <= gnt_data;
            end
        end
    end

    // Clear is applied first so a same-edge set on that register wins
    always_comb begin
        busy_nxt = busy;
        if (wb_wr_en) begin
            busy_nxt[wb_rd_addr] = 1'b0;
        end
        if (sb_set_en) begin
            busy_nxt[sb_set_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // No bypass: a register stays hazardous until its write has committed
    assign hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];

endmodule

// File: tb/tb_rv32_wb_port_arbiter.sv
// Self-checking bench for rv32_wb_port_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the port and scoreboard.
module tb_rv32_wb_port_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic                 wb_wr_en;
    logic [AW-1:0]        wb_rd_addr;
    logic [XLEN-1:0]      wb_rd_data;
    logic                 sb_set_en;
    logic [AW-1:0]        sb_set_addr;
    logic [AW-1:0]        chk_rs1;
    logic [AW-1:0]        chk_rs2;
    logic [AW-1:0]        chk_rd;
    logic                 hazard;
    logic [31:0]          busy;

    always #5 clk = ~clk;

    rv32_wb_port_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .REG_ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rd     (req_rd),
        .req_data   (req_data),
        .wb_wr_en   (wb_wr_en),
        .wb_rd_addr (wb_rd_addr),
        .wb_rd_data (wb_rd_data),
        .sb_set_en  (sb_set_en),
        .sb_set_addr(sb_set_addr),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .chk_rd     (chk_rd),
        .hazard     (hazard),
        .busy       (busy)
    );

    int ncmp  = 0;
    int nfail = 0;

    // Behavioural model state
    int          m_last;
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_busy;
    int          m_g;

    logic [NREQ-1:0] obs_ready;
    logic            obs_hazard;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = NREQ - 1;
        m_wen  = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_busy = '0;
        m_g    = -1;
    endtask

    function automatic int pick_grant();
        int g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int i = (m_last + k) % NREQ;
            if (g < 0 && req_valid[i]) g = i;
        end
        return g;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
        req_valid[i]         = v;
        req_rd[i*AW +: AW]   = rd;
        req_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic idle();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'd0, 32'd0);
        sb_set_en   = 1'b0;
        sb_set_addr = '0;
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle();
        int          g;
        logic [4:0]  g_rd;
        logic [31:0] g_data;
        logic [31:0] nb;
        logic        s_en;
        logic [4:0]  s_addr;
        #3;
        g = pick_grant();
        obs_ready  = req_ready;
        obs_hazard = hazard;
        check("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        check("hazard", 32'(hazard), 32'(m_busy[chk_rs1] | m_busy[chk_rs2] | m_busy[chk_rd]));
        g_rd   = (g >= 0) ? req_rd[g*AW +: AW] : 5'd0;
        g_data = (g >= 0) ? req_data[g*XLEN +: XLEN] : 32'd0;
        s_en   = sb_set_en;
        s_addr = sb_set_addr;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            nb = m_busy;
            if (m_wen) nb[m_addr] = 1'b0;
            if (s_en && s_addr != 0) nb[s_addr] = 1'b1;
            m_busy = nb;
            m_g = g;
            if (g >= 0) begin
                m_wen  = (g_rd != 0);
                m_addr = g_rd;
                m_data = g_data;
                m_last = g;
            end else begin
                m_wen = 1'b0;
            end
        end
        check("wb_wr_en", 32'(wb_wr_en), 32'(m_wen));
        check("wb_rd_addr", 32'(wb_rd_addr), 32'(m_addr));
        check("wb_rd_data", wb_rd_data, m_data);
        check("busy", busy, m_busy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_wen", 32'(wb_wr_en), 32'd0);
        check("rst_addr", 32'(wb_rd_addr), 32'd0);
        check("rst_data", wb_rd_data, 32'd0);
        check("rst_busy", busy, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int          waitc [NREQ];
        int          maxw;
        logic [31:0] bsave;

        rst = 1'b1;
        req_valid = '0;
        req_rd = '0;
        req_data = '0;
        sb_set_en = 1'b0;
        sb_set_addr = '0;
        chk_rs1 = '0;
        chk_rs2 = '0;
        chk_rd = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single requester 1 write
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        cycle();
        check("tp1_ready", 32'(obs_ready), 32'b010);
        check("tp1_wen", 32'(wb_wr_en), 32'd1);
        check("tp1_addr", 32'(wb_rd_addr), 32'd5);
        check("tp1_data", wb_rd_data, 32'hDEADBEEF);
        idle();
        cycle();
        check("tp1_wen_off", 32'(wb_wr_en), 32'd0);

        // Full contention round robin
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'b1, 5'(i + 12), 32'hA000_0000 + i);
            waitc[i] = 0;
        end
        maxw = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("rr_order", 32'(obs_ready), 32'd1 << (k % NREQ));
            for (int i = 0; i < NREQ; i++) begin
                if (obs_ready[i]) waitc[i] = 0;
                else waitc[i]++;
                if (waitc[i] > maxw) maxw = waitc[i];
            end
        end
        check("rr_maxwait_le2", 32'(maxw <= 2), 32'd1);
        idle();
        cycle();

        // Grant to x0: accepted, no write, busy untouched
        set_req(0, 1'b1, 5'd0, 32'h1234);
        bsave = busy;
        cycle();
        check("x0_ready0", 32'(obs_ready[0]), 32'd1);
        check("x0_wen", 32'(wb_wr_en), 32'd0);
        check("x0_busy", busy, bsave);
        idle();
        cycle();

        // Scoreboard set, write, clear
        sb_set_en = 1'b1;
        sb_set_addr = 5'd7;
        cycle();
        sb_set_en = 1'b0;
        chk_rs1 = 5'd7;
        set_req(2, 1'b1, 5'd7, 32'hCAFE0007);
        cycle();
        check("sb7_haz_grant", 32'(obs_hazard), 32'd1);
        idle();
        cycle();
        check("sb7_haz_wbcycle", 32'(obs_hazard), 32'd1);
        check("sb7_busy_clr", 32'(busy[7]), 32'd0);
        check("sb7_haz_clr", 32'(hazard), 32'd0);
        chk_rs1 = 5'd0;

        // Set and clear of r9 at the same edge
        set_req(0, 1'b1, 5'd9, 32'h0000_0099);
        cycle();
        idle();
        sb_set_en = 1'b1;
        sb_set_addr = 5'd9;
        cycle();
        sb_set_en = 1'b0;
        check("sb9_set_wins", 32'(busy[9]), 32'd1);
        #1;
        check("sb9_x0_haz", 32'(hazard), 32'd0);
        chk_rs1 = 5'd9;
        #1;
        check("sb9_rs1_haz", 32'(hazard), 32'd1);
        chk_rs1 = 5'd0;
        @(posedge clk);
        #1;
        m_busy = busy_model_step(m_busy);

        // Mid-cycle reset with busy=0xF00 and last_gnt=1
        do_reset();
        for (int a = 8; a < 12; a++) begin
            sb_set_en = 1'b1;
            sb_set_addr = 5'(a);
            if (a == 11) set_req(1, 1'b1, 5'd3, 32'h3333_3333);
            cycle();
        end
        idle();
        check("mr_busy_pre", busy, 32'h0000_0F00);
        check("mr_wen_pre", 32'(wb_wr_en), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mr_busy_rst", busy, 32'd0);
        check("mr_wen_rst", 32'(wb_wr_en), 32'd0);
        set_req(0, 1'b1, 5'd4, 32'h4444_0000);
        set_req(2, 1'b1, 5'd6, 32'h6666_0002);
        #1;
        check("mr_ready_in_rst", 32'(req_ready), 32'b001);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle();
        check("mr_first_grant", 32'(obs_ready), 32'b001);
        idle();
        cycle();

        // Randomized traffic honoring the hold-until-ready protocol
        for (int n = 0; n < 500; n++) begin
            chk_rs1 = 5'($urandom_range(0, 31));
            chk_rs2 = 5'($urandom_range(0, 31));
            chk_rd  = 5'($urandom_range(0, 31));
            sb_set_en   = ($urandom_range(0, 2) == 0);
            sb_set_addr = 5'($urandom_range(0, 31));
            cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || m_g == i)
                    set_req(i, ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 31)), $urandom);
            end
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    // Scoreboard advance for an idle edge (no set, clear of the pending write only)
    function automatic logic [31:0] busy_model_step(input logic [31:0] b);
        logic [31:0] r = b;
        if (m_wen) r[m_addr] = 1'b0;
        m_wen = 1'b0;
        return r;
    endfunction

endmodule
